// File: rtl/hlsm_sched_kernel.sv
// rtl/hlsm_sched_kernel.sv - multicycle-scheduled HLSM kernel: x=f-d, y=a-b, z=max-select(d,e)
module hlsm_sched_kernel #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2,
    parameter int SIGNED  = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic              Done,
    output logic              Busy,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] z
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_ADD  = 3'd1,
        S_MUL  = 3'd2,
        S_ALT  = 3'd3,
        S_CMP  = 3'd4,
        S_SEL  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] ra, rb, rc;
    logic              rsel;
    logic [DATA_W-1:0] d, e, f;
    logic              g;
    logic [DATA_W-1:0] xr, yr, zr;
    logic [CNT_W-1:0]  cnt;
    logic              gt;

    // SIGNED changes only how d and e are ordered; arithmetic is plain modulo 2^DATA_W
    always_comb begin
        gt = 1'b0;
        if (SIGNED != 0)
            gt = ($signed(d) > $signed(e));
        else
            gt = (d > e);
    end

    always_ff @(posedge Clk) begin
        if (Rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = S_ADD;
            S_ADD:   state_nxt = S_MUL;
            S_MUL:   if (cnt == '0) state_nxt = rsel ? S_ALT : S_CMP;
            S_ALT:   if (cnt == '0) state_nxt = S_CMP;
            S_CMP:   state_nxt = S_SEL;
            S_SEL:   state_nxt = S_DONE;
            S_DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ra   <= '0;
            rb   <= '0;
            rc   <= '0;
            rsel <= 1'b0;
            d    <= '0;
            e    <= '0;
            f    <= '0;
            g    <= 1'b0;
            xr   <= '0;
            yr   <= '0;
            zr   <= '0;
            cnt  <= '0;
            x    <= '0;
            y    <= '0;
            z    <= '0;
            Done <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        ra   <= a;
                        rb   <= b;
                        rc   <= c;
                        rsel <= sel;
                    end
                end
                S_ADD: begin
                    d   <= ra + rb;
                    e   <= ra + rc;
                    cnt <= CNT_INIT;
                end
                // The multiplier is modelled as occupied for MUL_LAT cycles; the product lands on the last one
                S_MUL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        f   <= ra * rc;
                        cnt <= CNT_INIT;
                    end
                end
                S_ALT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        yr <= ra - rb;
                        e  <= rb * rc;
                    end
                end
                S_CMP: begin
                    g  <= gt;
                    xr <= f - d;
                end
                S_SEL: begin
                    zr <= g ? d : e;
                end
                S_DONE: begin
                    x    <= xr;
                    z    <= zr;
                    if (rsel) y <= yr;
                    Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hlsm_sched_kernel.sv
// tb/tb_hlsm_sched_kernel.sv - scoreboard bench for hlsm_sched_kernel, unsigned and signed instances
module tb_hlsm_sched_kernel;

    localparam int DW = 32;
    localparam int ML = 2;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          Start = 1'b0;
    logic          sel = 1'b0;
    logic [DW-1:0] a = '0, b = '0, c = '0;

    logic          done_u, busy_u, done_s, busy_s;
    logic [DW-1:0] x_u, y_u, z_u, x_s, y_s, z_s;

    hlsm_sched_kernel #(.DATA_W(DW), .MUL_LAT(ML), .SIGNED(0)) u_dut_u (
        .Clk(Clk), .Rst(Rst), .Start(Start), .sel(sel), .a(a), .b(b), .c(c),
        .Done(done_u), .Busy(busy_u), .x(x_u), .y(y_u), .z(z_u)
    );

    hlsm_sched_kernel #(.DATA_W(DW), .MUL_LAT(ML), .SIGNED(1)) u_dut_s (
        .Clk(Clk), .Rst(Rst), .Start(Start), .sel(sel), .a(a), .b(b), .c(c),
        .Done(done_s), .Busy(busy_s), .x(x_s), .y(y_s), .z(z_s)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int            due;
        logic [DW-1:0] x, y, z0, z1;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            busy_until = 0;
    int            rst_edge = -1;
    logic [DW-1:0] model_y = '0;
    int            n_cmp = 0;
    int            n_bad = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, req);
        end
    endtask

    // Reference: results straight from the operation's definition, no notion of states
    function automatic exp_t model(input logic [DW-1:0] ai, bi, ci, input logic si,
                                   input logic [DW-1:0] yprev, input int due);
        exp_t          r;
        logic [DW-1:0] dv, ev, fv;
        dv = ai + bi;
        ev = si ? bi * ci : ai + ci;
        fv = ai * ci;
        r.due = due;
        r.x   = fv - dv;
        r.y   = si ? ai - bi : yprev;
        r.z0  = (dv > ev) ? dv : ev;
        r.z1  = ($signed(dv) > $signed(ev)) ? dv : ev;
        return r;
    endfunction

    task automatic drive(input logic r, input logic st, input logic sl,
                         input logic [DW-1:0] ai, input logic [DW-1:0] bi, input logic [DW-1:0] ci);
        int   k;
        int   lat;
        exp_t en;
        @(negedge Clk);
        Rst = r; Start = st; sel = sl; a = ai; b = bi; c = ci;
        k = cyc + 1;
        if (r) begin
            rst_edge   = k;
            busy_until = k;
            model_y    = '0;
            while (sb.size() > 0 && sb[sb.size()-1].due >= k) sb.pop_back();
        end else if (st && (k - 1 >= busy_until)) begin
            lat = sl ? 2 * ML + 4 : ML + 4;
            en  = model(ai, bi, ci, sl, model_y, k + lat);
            model_y = en.y;
            sb.push_back(en);
            busy_until = k + lat;
        end
    endtask

    task automatic idle_until_free();
        while (cyc < busy_until)
            drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
    endtask

    task automatic op(input logic sl, input logic [DW-1:0] ai, input logic [DW-1:0] bi, input logic [DW-1:0] ci);
        drive(1'b0, 1'b1, sl, ai, bi, ci);
        idle_until_free();
    endtask

    function automatic logic [DW-1:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return DW'($urandom_range(0, 15));
            1:       return $urandom;
            2:       return {1'b1, 31'($urandom)};
            default: return 32'hFFFF_FFFF - DW'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin : monitor
        exp_t          cur;
        logic          done_exp;
        int            n;
        logic [DW-1:0] cx = '0, cy = '0, cz0 = '0, cz1 = '0;
        forever begin
            @(posedge Clk);
            #1;
            n = cyc;
            if (n == rst_edge) begin
                cx = '0; cy = '0; cz0 = '0; cz1 = '0;
            end
            done_exp = 1'b0;
            if (sb.size() > 0 && sb[0].due == n) begin
                done_exp = 1'b1;
                cur = sb.pop_front();
                cx = cur.x; cy = cur.y; cz0 = cur.z0; cz1 = cur.z1;
            end
            chk("done_u", DW'(done_u), DW'(done_exp));
            chk("done_s", DW'(done_s), DW'(done_exp));
            chk("busy_u", DW'(busy_u), DW'(n < busy_until));
            chk("busy_s", DW'(busy_s), DW'(n < busy_until));
            chk("x_u", x_u, cx);
            chk("x_s", x_s, cx);
            chk("y_u", y_u, cy);
            chk("y_s", y_s, cy);
            chk("z_u", z_u, cz0);
            chk("z_s", z_s, cz1);
        end
    end

    initial begin : stimulus
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b1, 1'b1, 32'd7, 32'd7, 32'd7);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);

        op(1'b0, 32'd5, 32'd3, 32'd4);
        op(1'b1, 32'd5, 32'd3, 32'd4);
        op(1'b0, 32'd10, 32'd20, 32'd1);
        op(1'b0, 32'hFFFF_FFF0, 32'h20, 32'd1);

        // Start during S_MUL is dropped; Start in the Done cycle is taken
        drive(1'b0, 1'b1, 1'b0, 32'd5, 32'd3, 32'd4);
        drive(1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd9);
        drive(1'b0, 1'b1, 1'b1, 32'd100, 32'd200, 32'd300);
        idle_until_free();
        op(1'b0, 32'd1, 32'd1, 32'd1);

        // Reset while in S_MUL aborts without Done, then a clean rerun
        drive(1'b0, 1'b1, 1'b1, 32'd5, 32'd3, 32'd4);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        op(1'b0, 32'd5, 32'd3, 32'd4);

        for (int i = 0; i < 1500; i++)
            drive(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), rnd_val(), rnd_val(), rnd_val());

        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        idle_until_free();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("sb_drained", DW'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
